// File: rtl/req_fifo_mux_2.sv
// req_fifo_mux_2: two per-channel request FIFOs merged onto one output
// through an external 2-way round-robin arbiter (registered grant).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   inN_valid/data/ready per-channel push handshake (N = 0,1)
//   req                  registered non-empty flags to the arbiter
//   grant                one-hot grant from the arbiter (11 = illegal)
//   out_valid/data/src   merged output word and its source channel
//   out_ready            downstream accept
//   level0/level1        FIFO occupancy
//   err_grant            sticky illegal-grant flag
module req_fifo_mux_2 #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in0_valid,
   input  logic [DATA_W-1:0]        in0_data,
   output logic                     in0_ready,
   input  logic                     in1_valid,
   input  logic [DATA_W-1:0]        in1_data,
   output logic                     in1_ready,
   output logic [1:0]               req,
   input  logic [1:0]               grant,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_src,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level0,
   output logic [$clog2(DEPTH):0]   level1,
   output logic                     err_grant
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [DATA_W-1:0] r_mem [2][DEPTH];
   logic [PW-1:0]     r_wptr [2];
   logic [PW-1:0]     r_rptr [2];
   logic [LW-1:0]     r_lvl [2];
   logic [1:0]        r_req;
   logic              r_ov;
   logic [DATA_W-1:0] r_od;
   logic              r_os;
   logic              r_err;

   logic [DATA_W-1:0] w_din [2];
   logic [LW-1:0]     w_lvl_nxt [2];
   logic [1:0]        w_vin;
   logic [1:0]        w_full;
   logic [1:0]        w_nz;
   logic [1:0]        w_ready;
   logic [1:0]        w_push;
   logic [1:0]        w_gnt;
   logic [1:0]        w_pop;
   logic              w_slot;

   always_comb begin
      w_din[0] = in0_data;
      w_din[1] = in1_data;
      w_vin    = {in1_valid, in0_valid};
      for (int i = 0; i < 2; i++) begin
         w_full[i] = (r_lvl[i] == LW'(DEPTH));
         w_nz[i]   = (r_lvl[i] != '0);
      end
      // Ready is suppressed during reset and whenever full,
      // even if a pop happens in the same cycle.
      w_ready = ~w_full & {2{~rst}};
      w_push  = w_vin & w_ready;
      // grant 11 resolves to channel 0 only.
      w_gnt   = {grant[1] & ~grant[0], grant[0]};
      w_slot  = !r_ov || out_ready;
      // Stale grants to an empty FIFO or a busy slot are dropped.
      w_pop   = w_gnt & w_nz & {2{w_slot}};
      for (int i = 0; i < 2; i++) begin
         w_lvl_nxt[i] = r_lvl[i] + LW'(w_push[i]) - LW'(w_pop[i]);
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (w_push[i]) begin
            r_mem[i][r_wptr[i]] <= w_din[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
            r_lvl[i]  <= '0;
         end
         r_req <= 2'b00;
         r_ov  <= 1'b0;
         r_od  <= '0;
         r_os  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
               r_wptr[i] <= r_wptr[i] + PW'(1);
            end
            if (w_pop[i]) begin
               r_rptr[i] <= r_rptr[i] + PW'(1);
            end
            r_lvl[i] <= w_lvl_nxt[i];
            r_req[i] <= (w_lvl_nxt[i] != '0);
         end
         if (w_pop[0]) begin
            r_od <= r_mem[0][r_rptr[0]];
            r_os <= 1'b0;
            r_ov <= 1'b1;
         end else if (w_pop[1]) begin
            r_od <= r_mem[1][r_rptr[1]];
            r_os <= 1'b1;
            r_ov <= 1'b1;
         end else if (out_ready) begin
            r_ov <= 1'b0;
         end
         r_err <= r_err | (&grant);
      end
   end

   assign in0_ready = w_ready[0];
   assign in1_ready = w_ready[1];
   assign req       = r_req;
   assign out_valid = r_ov;
   assign out_data  = r_od;
   assign out_src   = r_os;
   assign level0    = r_lvl[0];
   assign level1    = r_lvl[1];
   assign err_grant = r_err;

endmodule
